// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t : one buffered instruction with its PC
//   cnt_t         : counter wide enough for any legal buffer depth (2..16)
//   NOP_INS       : ADDI x0,x0,0, presented to decode when nothing is valid
//   PC_STEP       : byte distance between consecutive instruction words
package fetch_pkg;

    localparam logic [31:0] NOP_INS   = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam int          MAX_DEPTH = 16;

    typedef logic [$clog2(MAX_DEPTH + 1)-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus plus the decode-side
// valid/ready handshake of the fetch stage.
//   master : the fetch unit (drives imem_req/imem_addr and id_valid/id_ins/id_pc)
//   slave  : the environment (memory and decode)
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_ins, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_ins, id_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered instruction buffer (no bypass).
//   clk, Rst     : clock and asynchronous active-high reset
//   push, wdata  : write one entry (never asserted while full)
//   pop, rdata   : rdata is the head entry, pop advances it (never while empty)
//   flush        : empties the buffer; wins over push and pop
//   count        : number of valid entries
//   empty, full  : occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         Rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output cnt_t         count,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t        mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;

    // Pointers wrap on their own because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // NOTE: the storage array has no reset; entries are only observed once
    // count says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == cnt_t'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage producing {pc, ins} pairs for decode.
//   clk, Rst    : clock and asynchronous active-high reset
//   bus         : fetch_if.master - imem request/grant, in-order responses,
//                 and the id_valid/id_ready handshake towards decode
//   redirect    : one-cycle pulse from execute restarting fetch
//   redirect_pc : new fetch address (low two bits ignored)
// Requests are credit based: words in flight plus words buffered never exceed
// DEPTH, so every response has a free buffer slot. On redirect, the words
// still in flight are counted in `kill` and discarded as they return.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        Rst,
    fetch_if.master     bus,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    logic [31:0]  fetch_pc;
    logic [31:0]  resp_pc;
    logic [31:0]  redirect_base;
    cnt_t         outstanding;
    cnt_t         kill;
    cnt_t         count;
    cnt_t         left_after_resp;
    logic         grant;
    logic         push;
    logic         pop;
    logic         empty;
    logic         full;
    logic         unused_sigs;
    fetch_entry_t head;
    fetch_entry_t wentry;

    assign redirect_base   = {redirect_pc[31:2], 2'b00};
    assign left_after_resp = outstanding - cnt_t'(bus.imem_rvalid);

    // Reset gates the request combinationally so it drops with the async reset.
    assign bus.imem_req  = !Rst && !redirect && ((outstanding + count) < cnt_t'(DEPTH));
    assign bus.imem_addr = fetch_pc;
    assign grant         = bus.imem_req && bus.imem_gnt;

    // Stale words (kill > 0) and anything arriving with a redirect are dropped.
    assign push   = bus.imem_rvalid && (kill == '0) && !redirect;
    assign pop    = bus.id_valid && bus.id_ready;
    assign wentry = '{pc: resp_pc, ins: bus.imem_rdata};

    // Credits make the full flag redundant; the low redirect bits are masked.
    assign unused_sigs = ^{redirect_pc[1:0], full};

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
        end else if (redirect) begin
            // No grant is possible here, only a response can retire.
            fetch_pc    <= redirect_base;
            resp_pc     <= redirect_base;
            outstanding <= left_after_resp;
            kill        <= left_after_resp;
        end else begin
            if (grant) fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding + cnt_t'(grant) - cnt_t'(bus.imem_rvalid);
            if (bus.imem_rvalid) begin
                if (kill != '0) kill    <= kill - cnt_t'(1);
                else            resp_pc <= resp_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // NOTE: every output gets a default before the condition so the block
    // stays purely combinational and no latch is inferred.
    always_comb begin
        bus.id_valid = !empty;
        bus.id_ins   = NOP_INS;
        bus.id_pc    = '0;
        if (!empty) begin
            bus.id_ins = head.ins;
            bus.id_pc  = head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        Rst;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_if bus ();
    fetch_if wbus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .Rst         (Rst),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Second instance starting near the top of the address space.
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk         (clk),
        .Rst         (Rst),
        .bus         (wbus),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h5A5A_3C3C;
    endfunction

    // ---------------- reference model ----------------
    // Each request is tagged with the redirect epoch it was issued in; a
    // response from an older epoch (or arriving with a redirect) is stale.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          ep;
        int          due;
    } req_t;

    req_t        pend [$];
    logic [31:0] mq [$];
    logic [31:0] next_pc;
    int          cur_epoch;
    int          cyc;
    int          lat_min;
    int          lat_max;
    logic        prev_rd;

    logic        w_pend;
    logic [31:0] w_addr_q;

    logic        s_req, s_valid, sw_req, sw_valid;
    logic [31:0] s_addr, s_pc, s_ins, sw_addr, sw_pc, sw_ins;

    // One clock cycle: drive inputs, sample and check outputs, advance model.
    // Entered and left at posedge+1.
    task automatic step(input logic rdy, input logic g, input logic rd, input logic [31:0] rpc);
        logic  rv;
        logic  exp_req;
        logic  do_pop;
        req_t  r;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.imem_gnt     = g;
        bus.id_ready     = rdy;
        bus.imem_rvalid  = rv;
        bus.imem_rdata   = rv ? mem_word(pend[0].addr) : $urandom;
        redirect         = rd;
        redirect_pc      = rpc;
        wbus.imem_gnt    = 1'b1;
        wbus.id_ready    = 1'b1;
        wbus.imem_rvalid = w_pend;
        wbus.imem_rdata  = mem_word(w_addr_q);
        #1;
        s_req  = bus.imem_req;   s_addr  = bus.imem_addr;
        s_valid = bus.id_valid;  s_pc    = bus.id_pc;    s_ins  = bus.id_ins;
        sw_req = wbus.imem_req;  sw_addr = wbus.imem_addr;
        sw_valid = wbus.id_valid; sw_pc  = wbus.id_pc;   sw_ins = wbus.id_ins;

        exp_req = !rd && ((pend.size() + mq.size()) < DEPTH);
        check1("imem_req", s_req, exp_req);
        if (s_req) check("imem_addr", s_addr, next_pc);
        check1("id_valid", s_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("id_pc", s_pc, mq[0]);
            check("id_ins", s_ins, mem_word(mq[0]));
        end else begin
            check("id_pc_idle", s_pc, 32'h0);
            check("id_ins_idle", s_ins, NOP_INS);
        end

        do_pop = !rd && rdy && (mq.size() != 0);
        if (do_pop) void'(mq.pop_front());
        if (rv) begin
            r = pend.pop_front();
            if (!rd && r.ep == cur_epoch) mq.push_back(r.exp_pc);
        end
        if (s_req && g) begin
            pend.push_back('{addr: s_addr, exp_pc: next_pc, ep: cur_epoch,
                             due: cyc + $urandom_range(lat_max, lat_min)});
            next_pc = next_pc + 32'd4;
        end
        if (rd) begin
            mq.delete();
            cur_epoch++;
            next_pc = {rpc[31:2], 2'b00};
        end
        w_pend   = sw_req;
        w_addr_q = sw_addr;
        prev_rd  = rd;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, checks outputs immediately (no clock edge), then releases
    // it at posedge+1 so the next step is cycle 0.
    task automatic do_reset();
        Rst = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        wbus.imem_gnt = 1'b0; wbus.imem_rvalid = 1'b0; wbus.imem_rdata = 32'h0;
        wbus.id_ready = 1'b0;
        #1;
        check1("rst_req", bus.imem_req, 1'b0);
        check1("rst_valid", bus.id_valid, 1'b0);
        check("rst_ins", bus.id_ins, NOP_INS);
        check("rst_pc", bus.id_pc, 32'h0);
        check1("rst_w_req", wbus.imem_req, 1'b0);
        check1("rst_w_valid", wbus.id_valid, 1'b0);
        check("rst_w_ins", wbus.id_ins, NOP_INS);
        pend.delete(); mq.delete();
        cur_epoch = 0; next_pc = 32'h0; cyc = 0; prev_rd = 1'b0;
        w_pend = 1'b0; w_addr_q = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        Rst = 1'b0;
    endtask

    // Steps with free-flowing decode until id_valid, then checks the head PC.
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end while (!s_valid && n < 20);
        check1({name, "_seen"}, s_valid, 1'b1);
        if (s_valid) check(name, s_pc, exp_pc);
    endtask

    // ---------------- table: straight-line fetch and backpressure ----------------
    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [20];
    logic [31:0] wexp [3];

    task automatic fill_vecs();
        vecs[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
        vecs[4]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
        vecs[5]  = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd8};
        for (int i = 6; i < 14; i++) vecs[i] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd8};
        vecs[14] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        vecs[15] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        vecs[16] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        vecs[17] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
        vecs[18] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd24};
        vecs[19] = '{1'b1, 1'b1, 32'd40, 1'b1, 32'd28};
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
    endtask

    initial begin
        fill_vecs();
        lat_min = 1;
        lat_max = 1;
        do_reset();

        // Straight-line fetch, 10-cycle stall, release; wrap instance alongside.
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rdy, 1'b1, 1'b0, 32'h0);
            check1("t_req", s_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check("t_addr", s_addr, vecs[i].exp_addr);
            check1("t_valid", s_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check("t_pc", s_pc, vecs[i].exp_pc);
                check("t_ins", s_ins, mem_word(vecs[i].exp_pc));
            end else begin
                check("t_ins_nop", s_ins, NOP_INS);
            end
            if (i < 3) begin
                check1("w_req", sw_req, 1'b1);
                check("w_addr", sw_addr, wexp[i]);
            end
            if (i >= 2 && i < 5) begin
                check1("w_valid", sw_valid, 1'b1);
                check("w_pc", sw_pc, wexp[i-2]);
                check("w_ins", sw_ins, mem_word(wexp[i-2]));
            end
        end

        // Redirect with three requests in flight at latency 3.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        check1("a_redir_no_req", s_req, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check1("a_new_req", s_req, 1'b1);
        check("a_new_addr", s_addr, 32'h0000_0100);
        check1("a_drain_valid", s_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check1("a_drain_valid", s_valid, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check1("a_first_valid", s_valid, 1'b1);
        check("a_first_pc", s_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a pop (latency 2).
        do_reset();
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        check1("b_pop_in_redir", s_valid, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check1("b_flushed", s_valid, 1'b0);
        wait_valid("b_first_pc", 32'h0000_0080);

        // Misaligned redirect target.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check1("c_req", s_req, 1'b1);
        check("c_addr", s_addr, 32'h0000_0200);
        wait_valid("c_first_pc", 32'h0000_0200);

        // Randomized traffic against the model.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 70, $urandom_range(99) < 75,
                 !prev_rd && ($urandom_range(99) < 4), $urandom);
        end

        // Async reset in the middle of a stalled burst.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check1("ar_pre_valid", s_valid, 1'b1);
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check1("ar_restart_valid", s_valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces `{pc, ins}` pairs for decode. The decode stage's immediate generator reads `ins` directly from this block. The block owns the program counter and issues word requests to instruction memory over a request/grant plus in-order response interface. Returned words are buffered in a small FIFO, and decode pops them with a valid/ready handshake. A redirect from execute (branch, jump or `jalr`) flushes the buffer and discards responses still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: instruction buffer entries. Must be a power of two, 2..16.
- `clk` in 1: sole clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address of the request. Bits [1:0] are always 0.
- `imem_gnt` in 1: the request is accepted in the cycle where `imem_req && imem_gnt`.
- `imem_rvalid` in 1: read data valid. Responses return in request order, at least 1 cycle after their grant.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: single-cycle pulse that restarts fetch.
- `redirect_pc` in 32: new fetch address. Bits [1:0] are ignored and forced to 0.
- `id_valid` out 1: a buffer entry is presented to decode.
- `id_ins` out 32: instruction at the buffer head. Equals 32'h0000_0013 (NOP) when `id_valid`=0.
- `id_pc` out 32: PC of `id_ins`. Equals 0 when `id_valid`=0.
- `id_ready` in 1: decode accepts the head entry. A pop occurs when `id_valid && id_ready`.

## Operation
- **State:** `fetch_pc`, `resp_pc`, `outstanding` (0..DEPTH), `kill` (0..DEPTH), and FIFO occupancy `count`.
- **Request rule:** `imem_req = !Rst && !redirect && (outstanding + count < DEPTH)`. This is credit based, so the FIFO can never overflow. `imem_addr = fetch_pc`.
- **Grant:** `fetch_pc += 4`, wrapping modulo 2^32. `outstanding` increments.
- **Response, `imem_rvalid`=1:** `outstanding` decrements.
  - If `kill > 0`, the word is dropped and `kill` decrements.
  - Otherwise `{resp_pc, imem_rdata}` is pushed and `resp_pc += 4`.
- **Grant and response in the same cycle:** `outstanding` is unchanged.
- **Redirect:** on the next edge:
  - `fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}`.
  - The FIFO is cleared.
  - `kill = outstanding - (imem_rvalid ? 1 : 0)`.
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle is ignored; the entry is flushed regardless.
- **Kill ordering:** responses to requests issued after a redirect always follow the killed ones, so `kill` exactly covers stale data.
- **FIFO:** push and pop in the same cycle are both allowed, including at `count`=DEPTH-1. A push never occurs while full, because of credits. A pop while empty is impossible because `id_valid`=0.

## Timing
- **Reset (async assert):** `fetch_pc` = `resp_pc` = RESET_PC. `outstanding` = `kill` = `count` = 0. `imem_req`=0, `id_valid`=0, `id_ins`=NOP, `id_pc`=0.
- **After reset release:** `imem_req`=1 with `imem_addr`=RESET_PC in the first cycle.
- **Latency:** grant at cycle N, `imem_rvalid` at N+1 or later. `id_valid` rises in the cycle after `imem_rvalid`, because the FIFO is registered and has no bypass.
- **Throughput:** with a 1-cycle memory and `id_ready` held high, one instruction per cycle in steady state at DEPTH=4.
- **Redirect penalty:** first request to the new PC in the cycle after the redirect. First `id_valid` for the new stream 2 cycles later, plus any stale responses still to drain.
- **Stall:** `id_ready`=0 holds the head entry and its outputs stable. Requests stop once `outstanding + count` = DEPTH.

## Structure
- **Package `fetch_pkg`:**
  - `fetch_entry_t` struct holding `pc` [31:0] and `ins` [31:0].
  - `NOP_INS` = 32'h0000_0013.
  - `PC_STEP` = 4.
- **Sub-module `fetch_fifo`:** synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`, with `push`, `pop`, `flush`, `count`, `empty` and `full`. It uses the same `clk` and `Rst`. `flush` has priority over push and pop.
- **Top level:** PC/credit/kill logic plus output muxing (NOP/0 when empty).

## Test plan
- **Reset and straight-line fetch:** release `Rst`, always-grant memory with 1-cycle response, `id_ready`=1. Required: `imem_addr` 0,4,8,…; `id_pc`/`id_ins` match memory contents, one per cycle starting 2 cycles after the first request; `id_ins`=0x13 before then.
- **Backpressure:** `id_ready`=0 for 10 cycles. Required: `count` saturates at 4, `imem_req` drops, head stays at the same PC. Release gives in-order continuation with no loss or duplication.
- **Redirect with in-flight requests:** memory latency 3 and 3 outstanding, pulse `redirect` with `redirect_pc`=0x100. Required: the 3 stale words are dropped, the next `id_pc`=0x100, and no entry with an old PC ever appears.
- **Redirect corner cases:**
  - Redirect coincident with `imem_rvalid` and a pop: the FIFO is empty next cycle and `kill` = `outstanding` - 1.
  - `redirect_pc`=0x203: fetch starts at 0x200.
- **Wrap-around and async reset:**
  - `RESET_PC`=32'hFFFF_FFF8: addresses run FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Assert `Rst` mid-burst: all outputs return to reset values immediately, without waiting for a clock edge.
